// File: rtl/i2s_dac_tx_pkg.sv
// Shared types and frame geometry for the I2S DAC transmitter.
// Pure definitions: no logic, no latency, no flow control.
package i2s_dac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } tx_state_t;

    localparam int FRAME_SLOTS = 64;
    localparam int SLOT_BITS   = 32;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    // Position of the bit carried in a slot, within the {left,right} pair; -1 means pad zero.
    function automatic int slot_bit_idx(input int sw, input int slot);
        if (slot >= 1 && slot <= sw)
            return 2 * sw - slot;
        if (slot >= SLOT_BITS + 1 && slot <= SLOT_BITS + sw)
            return sw + SLOT_BITS - slot;
        return -1;
    endfunction

endpackage

// File: rtl/i2s_dac_tx_sample_fifo.sv
// Show-ahead synchronous FIFO of stereo pairs; head visible on dout while not empty.
// Push accepted when not full or when popping in the same cycle; flush empties it in one cycle.
module i2s_dac_tx_sample_fifo #(
    parameter int W  = 48,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    assign full      = r_cnt[AW];
    assign empty     = (r_cnt == '0);
    assign level     = r_cnt;
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: FIFO-buffered stereo samples serialised MSB first, BCK/LRCK divided from clk.
// First BCK fall 2*BCK_DIV clk after RUN entry; s_ready = !full, silence plus underrun pulse when starved.
module i2s_dac_tx
    import i2s_dac_tx_pkg::*;
#(
    parameter int SW        = 24,
    parameter int BCK_DIV   = 2,
    parameter int FIFO_AW   = 3,
    parameter int PRIME_LVL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SW-1:0]    s_left,
    input  logic [SW-1:0]    s_right,
    output logic             dac_bck,
    output logic             dac_lrck,
    output logic             dac_data,
    output logic             underrun,
    output logic [FIFO_AW:0] fifo_level
);

    if (SW < 16 || SW > 31) begin : g_bad_sw
        $error("i2s_dac_tx: SW must be within 16..31");
    end
    if (BCK_DIV < 1) begin : g_bad_div
        $error("i2s_dac_tx: BCK_DIV must be at least 1");
    end
    if (PRIME_LVL < 1 || PRIME_LVL > 2 ** FIFO_AW) begin : g_bad_prime
        $error("i2s_dac_tx: PRIME_LVL must be within 1..2**FIFO_AW");
    end

    localparam int PH_W = $clog2(2 * BCK_DIV);
    localparam int IDX_W = $clog2(2 * SW);
    localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(2 * BCK_DIV - 1);
    localparam logic [PH_W-1:0]    PH_HALF   = PH_W'(BCK_DIV);
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);
    localparam logic [SLOT_W-1:0]  HALF_SLOT = SLOT_W'(SLOT_BITS);
    localparam logic [FIFO_AW:0]   PRIME_CNT = (FIFO_AW + 1)'(PRIME_LVL);

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic               w_stay_run;
    logic               w_flush;
    logic [PH_W-1:0]    r_ph;
    logic [PH_W-1:0]    w_ph_nxt;
    logic [SLOT_W-1:0]  r_slot;
    logic [SLOT_W-1:0]  w_slot_nxt;
    logic [2*SW-1:0]    r_frame;
    logic [2*SW-1:0]    w_frame_nxt;
    logic [2*SW-1:0]    w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FIFO_AW:0]   w_level;
    logic               w_push;
    logic               w_pop;
    logic               w_fall;
    logic               w_load;
    logic               w_bit;
    int                 w_idx;
    logic               r_bck;
    logic               r_lrck;
    logic               r_data;
    logic               r_underrun;

    i2s_dac_tx_sample_fifo #(
        .W  (2 * SW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({s_left, s_right}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_level)
    );

    assign s_ready    = !w_fifo_full;
    assign w_push     = s_valid && s_ready;
    assign fifo_level = w_level;
    assign dac_bck    = r_bck;
    assign dac_lrck   = r_lrck;
    assign dac_data   = r_data;
    assign underrun   = r_underrun;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (en) w_state_nxt = FILL;
            FILL: begin
                if (!en)
                    w_state_nxt = IDLE;
                else if (w_level >= PRIME_CNT)
                    w_state_nxt = RUN;
            end
            RUN:  if (!en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Leaving RUN both flushes the FIFO and drops the serial outputs back to idle values.
    always_comb begin
        w_stay_run = (r_state == RUN) && en;
        w_flush    = (r_state == RUN) && !en;
    end

    assign w_ph_nxt   = (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
    assign w_slot_nxt = r_slot + 1'b1;
    assign w_fall     = w_stay_run && (r_ph == PH_LAST);
    assign w_load     = w_fall && (r_slot == LAST_SLOT);
    assign w_pop      = w_load && !w_fifo_empty;
    assign w_frame_nxt = !w_load ? r_frame : (w_fifo_empty ? '0 : w_fifo_dout);

    always_comb begin
        w_idx = slot_bit_idx(SW, int'(w_slot_nxt));
        w_bit = 1'b0;
        if (w_idx >= 0)
            w_bit = w_frame_nxt[IDX_W'($unsigned(w_idx))];
    end

    // LRCK and data move on the BCK fall so the DAC sees them stable at the next rise.
    always_ff @(posedge clk) begin
        if (rst || !w_stay_run) begin
            r_ph       <= '0;
            r_slot     <= LAST_SLOT;
            r_frame    <= '0;
            r_bck      <= 1'b0;
            r_lrck     <= 1'b1;
            r_data     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_ph       <= w_ph_nxt;
            r_bck      <= (w_ph_nxt >= PH_HALF);
            r_frame    <= w_frame_nxt;
            r_underrun <= w_load && w_fifo_empty;
            if (w_fall) begin
                r_slot <= w_slot_nxt;
                r_lrck <= (w_slot_nxt >= HALF_SLOT);
                r_data <= w_bit;
            end
        end
    end

endmodule
